// File: rtl/icache_fetch_if.sv
// Fetch-side bus of the instruction cache: the instruction unit's PC/request
// lookup path together with the memory unit's line-refill beat port.
interface icache_fetch_if;
  // Instruction unit lookup
  logic [31:0] pc_in;
  logic        inst_req;
  logic        inst_ready;
  logic [31:0] inst;
  // Memory unit refill port
  logic        mem_busy;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_valid;
  logic [31:0] refill_data;

  // Environment side: instruction unit plus memory unit
  modport master (
    output pc_in, inst_req, refill_valid, refill_data,
    input  inst_ready, inst, mem_busy, refill_req, refill_addr
  );

  // Cache side
  modport slave (
    input  pc_in, inst_req, refill_valid, refill_data,
    output inst_ready, inst, mem_busy, refill_req, refill_addr
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache responder with 16-byte lines.
// Lookups are combinational on halfword-aligned PCs so that compressed and
// line-straddling 32-bit instructions are both served; misses run a 4-beat
// line refill against the memory unit, one line at a time.
module icache_fetch #(
  parameter int INDEX_BIT = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  icache_fetch_if.slave bus
);

  localparam int LINES = 1 << INDEX_BIT;
  localparam int TAG_W = 28 - INDEX_BIT;

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  // Line storage
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][4];

  // Refill control registers
  state_e      state_q,    state_d;
  logic        req_q,      req_d;
  logic        busy_q,     busy_d;
  logic [31:0] ref_addr_q, ref_addr_d;
  logic [1:0]  cnt_q,      cnt_d;

  // Storage write strobes decoded by the FSM
  logic beat_we;
  logic line_done;

  // Lookup datapath signals
  logic [31:0]          addr_a;
  logic [31:0]          addr_b;
  logic [INDEX_BIT-1:0] idx_a;
  logic [INDEX_BIT-1:0] idx_b;
  logic [TAG_W-1:0]     tag_a;
  logic [TAG_W-1:0]     tag_b;
  logic [31:0]          word_a;
  logic [31:0]          word_b;
  logic [15:0]          lo;
  logic [15:0]          hi;
  logic                 hit_a;
  logic                 hit_b;
  logic                 compressed;
  logic                 ready;
  logic [31:0]          miss_base;

  // Refill target fields come straight from the held line address
  logic [INDEX_BIT-1:0] ref_idx;
  logic [TAG_W-1:0]     ref_tag;

  // Address bit 0 never selects anything: fetches are halfword-granular
  logic unused_bits;

  assign addr_a = {bus.pc_in[31:1], 1'b0};
  assign addr_b = addr_a + 32'd2;

  assign idx_a = addr_a[3+INDEX_BIT:4];
  assign idx_b = addr_b[3+INDEX_BIT:4];
  assign tag_a = addr_a[31:4+INDEX_BIT];
  assign tag_b = addr_b[31:4+INDEX_BIT];

  assign ref_idx = ref_addr_q[3+INDEX_BIT:4];
  assign ref_tag = ref_addr_q[31:4+INDEX_BIT];

  assign unused_bits = ^{bus.pc_in[0], addr_a[0], addr_b[0]};

  // Hit path: pick the low halfword at A and the high halfword at A+2,
  // which may come from the next word or, at offset 14, the next line
  always_comb begin
    word_a     = data_q[idx_a][addr_a[3:2]];
    word_b     = data_q[idx_b][addr_b[3:2]];
    lo         = addr_a[1] ? word_a[31:16] : word_a[15:0];
    hi         = addr_b[1] ? word_b[31:16] : word_b[15:0];
    hit_a      = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    hit_b      = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
    compressed = (lo[1:0] != 2'b11);
    ready      = hit_a && (compressed || hit_b);
    miss_base  = hit_a ? {addr_b[31:4], 4'b0000} : {addr_a[31:4], 4'b0000};
  end

  assign bus.inst_ready  = ready;
  assign bus.inst        = {hi, lo};
  assign bus.refill_req  = req_q;
  assign bus.mem_busy    = busy_q;
  assign bus.refill_addr = ref_addr_q;

  // Refill FSM next state: latch the missing line in IDLE, count beats in REFILL
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    busy_d     = busy_q;
    ref_addr_d = ref_addr_q;
    cnt_d      = cnt_q;
    beat_we    = 1'b0;
    line_done  = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (bus.inst_req && !ready) begin
            ref_addr_d = miss_base;
            req_d      = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = 2'd0;
            state_d    = REFILL;
          end
        end
        REFILL: begin
          if (bus.refill_valid) begin
            beat_we = 1'b1;
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              line_done = 1'b1;
              req_d     = 1'b0;
              busy_d    = 1'b0;
              state_d   = IDLE;
            end
          end
        end
      endcase
    end
  end

  // Refill FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      ref_addr_q <= 32'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      ref_addr_q <= ref_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Valid bits: dropped on the first beat so a half-written line never hits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (beat_we && (cnt_q == 2'd0)) begin
      valid_q[ref_idx] <= 1'b0;
    end else if (line_done) begin
      valid_q[ref_idx] <= 1'b1;
    end
  end

  // Data and tag arrays need no reset; valid_q gates every use of them
  always_ff @(posedge clk_in) begin
    if (beat_we) begin
      data_q[ref_idx][cnt_q] <= bus.refill_data;
    end
    if (line_done) begin
      tag_q[ref_idx] <= ref_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: drives fetches and refill beats, and keeps
// expected instruction words in a scoreboard queue until the cache answers.
module tb_icache_fetch;

  logic clk;
  logic rstN;
  logic rdy;

  icache_fetch_if ifc ();

  icache_fetch #(.INDEX_BIT(4)) dut (
    .clk_in (clk),
    .rst_in (rstN),
    .rdy_in (rdy),
    .bus    (ifc)
  );

  typedef struct {
    string       tag;
    logic [31:0] inst;
    logic [31:0] mask;
  } expEntry_t;

  expEntry_t sbQ[$];
  int checkCount = 0;
  int errorCount = 0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic req);
    ifc.pc_in    = pc;
    ifc.inst_req = req;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic issueFetch(input string tag, input logic [31:0] pc,
                            input logic [31:0] expInst, input logic [31:0] mask);
    expEntry_t e;
    e.tag  = tag;
    e.inst = expInst;
    e.mask = mask;
    sbQ.push_back(e);
    applyStimulus(pc, 1'b1);
  endtask

  task automatic checkFetch(input int budget);
    expEntry_t e;
    for (int i = 0; i < budget && ifc.inst_ready !== 1'b1; i++) tick();
    e = sbQ.pop_front();
    checkOutput({e.tag, " ready"}, {31'd0, ifc.inst_ready}, 32'd1);
    checkOutput(e.tag, ifc.inst & e.mask, e.inst & e.mask);
  endtask

  task automatic waitRefill(input string tag, input logic [31:0] addr, input int budget);
    for (int i = 0; i < budget && ifc.refill_req !== 1'b1; i++) tick();
    checkOutput({tag, " req"}, {31'd0, ifc.refill_req}, 32'd1);
    checkOutput({tag, " addr"}, ifc.refill_addr, addr);
    checkOutput({tag, " busy"}, {31'd0, ifc.mem_busy}, 32'd1);
  endtask

  task automatic sendBeat(input logic [31:0] data);
    ifc.refill_valid = 1'b1;
    ifc.refill_data  = data;
    tick();
    ifc.refill_valid = 1'b0;
    #1;
  endtask

  task automatic feedLine(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    sendBeat(w0);
    sendBeat(w1);
    sendBeat(w2);
    sendBeat(w3);
  endtask

  initial begin
    rstN             = 1'b0;
    rdy              = 1'b1;
    ifc.pc_in        = 32'd0;
    ifc.inst_req     = 1'b0;
    ifc.refill_valid = 1'b0;
    ifc.refill_data  = 32'd0;
    tick();
    tick();

    // Reset state
    checkOutput("reset refill_req", {31'd0, ifc.refill_req}, 32'd0);
    checkOutput("reset mem_busy", {31'd0, ifc.mem_busy}, 32'd0);
    checkOutput("reset refill_addr", ifc.refill_addr, 32'd0);
    checkOutput("reset inst_ready", {31'd0, ifc.inst_ready}, 32'd0);
    rstN = 1'b1;
    tick();

    // Cold miss at PC 0
    issueFetch("cold pc0", 32'h0, 32'h00000013, 32'hFFFFFFFF);
    checkOutput("cold miss ready", {31'd0, ifc.inst_ready}, 32'd0);
    checkOutput("cold req before edge", {31'd0, ifc.refill_req}, 32'd0);
    tick();
    waitRefill("cold", 32'h0, 0);
    feedLine(32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193);
    checkOutput("cold busy drop", {31'd0, ifc.mem_busy}, 32'd0);
    checkOutput("cold req drop", {31'd0, ifc.refill_req}, 32'd0);
    checkFetch(0);
    issueFetch("cold pc8", 32'h8, 32'h00200113, 32'hFFFFFFFF);
    checkFetch(0);

    // Conflict eviction of line 0 by 0x100
    issueFetch("evict 0x100", 32'h100, 32'h00400213, 32'hFFFFFFFF);
    checkOutput("evict miss ready", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    waitRefill("evict", 32'h100, 0);
    feedLine(32'h00400213, 32'h00500293, 32'h00600313, 32'h00700393);
    checkFetch(0);
    issueFetch("refetch pc0", 32'h0, 32'h00000013, 32'hFFFFFFFF);
    checkOutput("refetch miss ready", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    waitRefill("refetch", 32'h0, 0);
    sendBeat(32'h00000013);
    applyStimulus(32'h100, 1'b1);
    checkOutput("partial line no hit", {31'd0, ifc.inst_ready}, 32'd0);
    applyStimulus(32'h0, 1'b1);
    sendBeat(32'h00100093);
    sendBeat(32'h00200113);
    sendBeat(32'h0513ABCD);
    checkFetch(0);

    // Straddling 32-bit instruction, next line absent
    issueFetch("straddle32", 32'hE, 32'h05930513, 32'hFFFFFFFF);
    checkOutput("straddle32 miss ready", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    waitRefill("straddle32", 32'h10, 0);
    feedLine(32'h00A50593, 32'h00000013, 32'h00000013, 32'h00000013);
    checkFetch(0);

    // Straddling compressed instruction served without touching the next line
    issueFetch("line 0x20", 32'h20, 32'h00C00613, 32'hFFFFFFFF);
    tick();
    waitRefill("line 0x20", 32'h20, 0);
    feedLine(32'h00C00613, 32'h00000013, 32'h00000013, 32'h4505ABCD);
    checkFetch(0);
    issueFetch("straddle rvc", 32'h2E, 32'h00004505, 32'h0000FFFF);
    checkFetch(0);
    tick();
    checkOutput("rvc no refill 1", {31'd0, ifc.refill_req}, 32'd0);
    tick();
    checkOutput("rvc no refill 2", {31'd0, ifc.refill_req}, 32'd0);

    // Straddle with both lines absent: A's line first, then B's
    issueFetch("double straddle", 32'h3E, 32'hA6B70667, 32'hFFFFFFFF);
    checkOutput("double miss ready", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    waitRefill("double A", 32'h30, 0);
    feedLine(32'h00000013, 32'h00000013, 32'h00000013, 32'h0667ABCD);
    checkOutput("double B pending", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    waitRefill("double B", 32'h40, 0);
    feedLine(32'h0000A6B7, 32'h00000013, 32'h00000013, 32'h00000013);
    checkFetch(0);

    // Gaps between beats and a 3-cycle stall with a beat offered
    issueFetch("stall w0", 32'h50, 32'h00800413, 32'hFFFFFFFF);
    tick();
    waitRefill("stall", 32'h50, 0);
    sendBeat(32'h00800413);
    checkOutput("stall partial", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    tick();
    rdy = 1'b0;
    ifc.refill_valid = 1'b1;
    ifc.refill_data  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall busy", {31'd0, ifc.mem_busy}, 32'd1);
      checkOutput("stall ready", {31'd0, ifc.inst_ready}, 32'd0);
    end
    rdy = 1'b1;
    ifc.refill_valid = 1'b0;
    #1;
    sendBeat(32'h00900493);
    sendBeat(32'h00A00513);
    checkOutput("stall still busy", {31'd0, ifc.mem_busy}, 32'd1);
    sendBeat(32'h00B00593);
    checkOutput("stall done", {31'd0, ifc.refill_req}, 32'd0);
    checkFetch(0);
    issueFetch("stall w1", 32'h54, 32'h00900493, 32'hFFFFFFFF);
    checkFetch(0);
    issueFetch("stall w2", 32'h58, 32'h00A00513, 32'hFFFFFFFF);
    checkFetch(0);
    issueFetch("stall w3", 32'h5C, 32'h00B00593, 32'hFFFFFFFF);
    checkFetch(0);

    // Beats while IDLE are ignored
    applyStimulus(32'h50, 1'b0);
    ifc.refill_valid = 1'b1;
    ifc.refill_data  = 32'hFFFFFFFF;
    tick();
    tick();
    ifc.refill_valid = 1'b0;
    #1;
    checkOutput("idle beat req", {31'd0, ifc.refill_req}, 32'd0);
    checkOutput("idle beat busy", {31'd0, ifc.mem_busy}, 32'd0);
    issueFetch("idle beat data", 32'h54, 32'h00900493, 32'hFFFFFFFF);
    checkFetch(0);

    // Asynchronous reset in the middle of a refill
    issueFetch("reset mid", 32'h60, 32'h0, 32'h0);
    tick();
    waitRefill("reset mid", 32'h60, 0);
    void'(sbQ.pop_front());
    sendBeat(32'h00000013);
    sendBeat(32'h00000013);
    rstN = 1'b0;
    #1;
    checkOutput("async reset req", {31'd0, ifc.refill_req}, 32'd0);
    checkOutput("async reset busy", {31'd0, ifc.mem_busy}, 32'd0);
    applyStimulus(32'h0, 1'b0);
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("post reset pc0", {31'd0, ifc.inst_ready}, 32'd0);
    checkOutput("post reset addr", ifc.refill_addr, 32'd0);
    applyStimulus(32'h50, 1'b0);
    checkOutput("post reset pc50", {31'd0, ifc.inst_ready}, 32'd0);
    tick();
    checkOutput("post reset idle", {31'd0, ifc.refill_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
